// File: rtl/freq_pkg.sv
// Shared types and helpers for the gated frequency-measurement controller:
// FSM state encoding, gate range codes and range-to-gate-length mapping.
package freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GATE   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam logic [1:0] RANGE_10MS  = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_1S    = 2'd2;

  localparam int LO_THRESH_DEF = 1000;

  // Code 3 is an alias for the longest gate.
  function automatic logic [1:0] map_range(input logic [1:0] sel);
    return (sel == 2'd3) ? RANGE_1S : sel;
  endfunction

  function automatic int unsigned gate_len(input logic [1:0] rng, input int unsigned clk_hz);
    case (rng)
      RANGE_10MS:  return clk_hz / 100;
      RANGE_100MS: return clk_hz / 10;
      default:     return clk_hz;
    endcase
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Gate-length down-counter: load_i presets N-1, enable_i counts down to zero
// and holds there; done_o flags the final gate cycle.
module gate_timer #(
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] n_i,
  input  logic          enable_i,
  output logic          done_o
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = (n_i == '0) ? '0 : n_i - TW'(1);
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gated frequency-counter controller: clears an external edge counter, gates
// it for a range-dependent window, captures the count and offers it on a
// valid/ready port. Optional auto-ranging is enabled by FREQ_AUTORANGE_EN.
//
// Handshake: result_valid stays high with result/result_range/overrange frozen
// until a cycle with result_valid & result_ready; valid drops the next cycle.
module freq_gate_ctrl
  import freq_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CNT_W     = 23,
  parameter int LO_THRESH = LO_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       range_sel,
  input  logic [CNT_W-1:0] count_in,
  input  logic             ovf_in,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [CNT_W-1:0] result,
  output logic [1:0]       result_range,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             overrange,
  output state_e           state_dbg
);

  localparam int TW = $clog2(CLK_HZ + 1);

  state_e           state_q, state_d;
  logic             settle_q, settle_d;
  logic [1:0]       cur_range_q, cur_range_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [1:0]       result_range_q, result_range_d;
  logic             overrange_q, overrange_d;
  logic             timer_done;
  logic             capture;
  logic             transfer;

  gate_timer #(.TW(TW)) u_gate_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (state_q == ST_CLEAR),
    .n_i      (TW'(gate_len(cur_range_q, CLK_HZ))),
    .enable_i (state_q == ST_GATE),
    .done_o   (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = run ? ST_GATE : ST_IDLE;
      ST_GATE: begin
        if (!run)           state_d = ST_IDLE;
        else if (timer_done) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!run)          state_d = ST_IDLE;
        else if (settle_q) state_d = ST_HOLD;
      end
      ST_HOLD:   if (result_ready) state_d = run ? ST_CLEAR : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_clear    = (state_q == ST_CLEAR);
    cnt_enable   = (state_q == ST_GATE);
    result_valid = (state_q == ST_HOLD);
    busy         = (state_q != ST_IDLE);
  end

  assign capture  = (state_q == ST_SETTLE) && settle_q && run;
  assign transfer = (state_q == ST_HOLD) && result_ready;

  always_comb begin
    settle_d       = (state_q == ST_SETTLE) && !settle_q;
    cur_range_d    = cur_range_q;
    result_d       = result_q;
    result_range_d = result_range_q;
    overrange_d    = overrange_q;
    if (capture) begin
      result_d       = count_in;
      result_range_d = cur_range_q;
      overrange_d    = ovf_in;
    end
    if ((state_q == ST_IDLE) && run) begin
      cur_range_d = map_range(range_sel);
    end
`ifdef FREQ_AUTORANGE_EN
    // Overflow shortens the next gate; a small count lengthens it.
    if (capture) begin
      if (ovf_in) begin
        cur_range_d = (cur_range_q == RANGE_10MS) ? RANGE_10MS : cur_range_q - 2'd1;
      end else if (count_in < CNT_W'(LO_THRESH)) begin
        cur_range_d = (cur_range_q >= RANGE_1S) ? RANGE_1S : cur_range_q + 2'd1;
      end
    end
`else
    if (transfer && run) begin
      cur_range_d = map_range(range_sel);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q       <= 1'b0;
      cur_range_q    <= 2'd0;
      result_q       <= '0;
      result_range_q <= 2'd0;
      overrange_q    <= 1'b0;
    end else begin
      settle_q       <= settle_d;
      cur_range_q    <= cur_range_d;
      result_q       <= result_d;
      result_range_q <= result_range_d;
      overrange_q    <= overrange_d;
    end
  end

  assign result       = result_q;
  assign result_range = result_range_q;
  assign overrange    = overrange_q;
  assign state_dbg    = state_q;

endmodule
